// File: rtl/alu_issue_ctrl.sv
// Issue controller for an external ALU. It accepts one request at a time and triggers the ALU by toggling alu_en.
// It captures the ALU outputs and holds the response until the consumer takes it.
module alu_issue_ctrl (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [2:0]  req_op,
   input  logic [31:0] req_a,
   input  logic [31:0] req_b,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [1:0]  alu_op,
   output logic        alu_en,
   input  logic [31:0] alu_result,
   input  logic        alu_zero,
   input  logic        alu_neg,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_result,
   output logic        resp_zero,
   output logic        resp_neg,
   output logic        resp_taken,
   output logic        resp_wb,
   output logic        resp_err,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t      r_state;
   logic [2:0]  r_op;
   logic [31:0] r_alu_a;
   logic [31:0] r_alu_b;
   logic [1:0]  r_alu_op;
   logic        r_alu_en;
   logic [31:0] r_resp_result;
   logic        r_resp_zero;
   logic        r_resp_neg;
   logic        r_resp_taken;
   logic        r_resp_wb;
   logic        r_resp_err;

   logic        w_accept;
   logic        w_illegal;
   logic [1:0]  w_dec_op;
   logic        w_taken;
   logic        w_wb;

   assign w_accept  = req_valid && (r_state == IDLE);
   assign w_illegal = (req_op == 3'b111);
   assign w_wb      = (r_op < 3'd3);

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      w_dec_op = 2'b10;
      case (req_op)
         3'b000:  w_dec_op = 2'b00;
         3'b001:  w_dec_op = 2'b01;
         default: w_dec_op = 2'b10;
      endcase
   end

   always_comb begin
      w_taken = 1'b0;
      case (r_op)
         3'b100:  w_taken = alu_zero;
         3'b101:  w_taken = !alu_zero;
         3'b110:  w_taken = alu_neg;
         default: w_taken = 1'b0;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state       <= IDLE;
         r_op          <= 3'b000;
         r_alu_a       <= '0;
         r_alu_b       <= '0;
         r_alu_op      <= 2'b00;
         r_alu_en      <= 1'b0;
         r_resp_result <= '0;
         r_resp_zero   <= 1'b0;
         r_resp_neg    <= 1'b0;
         r_resp_taken  <= 1'b0;
         r_resp_wb     <= 1'b0;
         r_resp_err    <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  if (w_illegal) begin
                     // Illegal ops never reach the ALU; the operand registers keep their last issued values.
                     r_state       <= RESP;
                     r_resp_result <= '0;
                     r_resp_zero   <= 1'b0;
                     r_resp_neg    <= 1'b0;
                     r_resp_taken  <= 1'b0;
                     r_resp_wb     <= 1'b0;
                     r_resp_err    <= 1'b1;
                  end else begin
                     r_state  <= ISSUE;
                     r_op     <= req_op;
                     r_alu_a  <= req_a;
                     r_alu_b  <= req_b;
                     r_alu_op <= w_dec_op;
                     r_alu_en <= ~r_alu_en;
                  end
               end
            end
            ISSUE: r_state <= WAIT;
            WAIT: begin
               r_state       <= RESP;
               r_resp_result <= alu_result;
               r_resp_zero   <= alu_zero;
               r_resp_neg    <= alu_neg;
               r_resp_taken  <= w_taken;
               r_resp_wb     <= w_wb;
               r_resp_err    <= 1'b0;
            end
            RESP: begin
               if (resp_ready) r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign req_ready   = (r_state == IDLE);
   assign busy        = (r_state != IDLE);
   assign resp_valid  = (r_state == RESP);
   assign alu_a       = r_alu_a;
   assign alu_b       = r_alu_b;
   assign alu_op      = r_alu_op;
   assign alu_en      = r_alu_en;
   assign resp_result = r_resp_result;
   assign resp_zero   = r_resp_zero;
   assign resp_neg    = r_resp_neg;
   assign resp_taken  = r_resp_taken;
   assign resp_wb     = r_resp_wb;
   assign resp_err    = r_resp_err;

endmodule
